tx_engine: RTL and testbench

- Serial transmit stage that sits directly downstream of the prefetcher's TX interface and the execute unit's memory-request port.
- Arbitrates between the two command sources and frames each message as start bit, header, then one or two payloads.
- Drives the IO_BITS-wide tx pins and streams payload data from the selected source using a per-cycle tx_data_next strobe and tx_counter.

---
 rtl/tx_engine_pkg.sv | 31 +++
 rtl/tx_arbiter.sv | 22 ++
 rtl/tx_engine.sv | 131 +++++++++++++
 tb/tb_tx_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_engine_pkg.sv
// Shared definitions for the tx_engine slice: default sizing, header
// encodings, header bit positions, FSM state and source-select types.
package tx_engine_pkg;

  localparam int TX_IO_BITS        = 2;
  localparam int TX_PAYLOAD_CYCLES = 8;
  localparam int TX_CMD_BITS       = 4;

  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_8   = 4'h0;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 4'h1;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 4'h2;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'h3;

  // bit0 selects a 16-bit access; bit1 marks a write (address then data)
  localparam int TX_HDR_BIT_16    = 0;
  localparam int TX_HDR_BIT_WRITE = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_e;

  typedef enum logic {
    SRC_PF = 1'b0,
    SRC_EX = 1'b1
  } tx_src_e;

endpackage

// File: rtl/tx_arbiter.sv
// Fixed-priority accept logic for the two command sources; the execute
// unit wins when both request in the same cycle.
module tx_arbiter
  import tx_engine_pkg::*;
(
  input  logic    enable,
  input  logic    pf_valid,
  input  logic    ex_valid,
  output logic    pf_started,
  output logic    ex_started,
  output logic    accept,
  output tx_src_e sel
);

  always_comb begin
    ex_started = enable && ex_valid;
    pf_started = enable && pf_valid && !ex_valid;
    accept     = ex_started || pf_started;
    sel        = ex_valid ? SRC_EX : SRC_PF;
  end

endmodule

// File: rtl/tx_engine.sv
// Serial transmit stage: accepts one command at a time and frames it as a
// start beat, LSB-first header chunks, one or two payloads and a gap beat.
module tx_engine #(
  parameter int IO_BITS        = tx_engine_pkg::TX_IO_BITS,
  parameter int PAYLOAD_CYCLES = tx_engine_pkg::TX_PAYLOAD_CYCLES,
  parameter int TX_CMD_BITS    = tx_engine_pkg::TX_CMD_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            hold,
  input  logic                            pf_cmd_valid,
  input  logic [TX_CMD_BITS-1:0]          pf_cmd,
  output logic                            pf_started,
  input  logic [IO_BITS-1:0]              pf_data,
  input  logic                            ex_cmd_valid,
  input  logic [TX_CMD_BITS-1:0]          ex_cmd,
  output logic                            ex_started,
  input  logic [IO_BITS-1:0]              ex_data,
  output logic                            tx_active,
  output logic                            tx_source,
  output logic                            tx_data_next,
  output logic [$clog2(PAYLOAD_CYCLES):0] tx_counter,
  output logic                            tx_done,
  output logic [IO_BITS-1:0]              tx_pins
);
  import tx_engine_pkg::*;

  localparam int HDR_BEATS = TX_CMD_BITS / IO_BITS;
  localparam int HDR_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int CNT_W     = $clog2(PAYLOAD_CYCLES) + 1;

  localparam logic [HDR_W-1:0] HDR_LAST   = HDR_W'(HDR_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_READ  = CNT_W'(PAYLOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_WRITE = CNT_W'(2 * PAYLOAD_CYCLES - 1);

  tx_state_e              state_q, state_d;
  tx_src_e                src_q, src_sel;
  logic [TX_CMD_BITS-1:0] shift_q, shift_d, cmd_sel;
  logic                   write_q;
  logic [HDR_W-1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, last_beat;
  logic [IO_BITS-1:0]     pin_d;
  logic                   accept, arb_enable;

  // Holding reset must also silence the combinational started pulses.
  assign arb_enable = rst_n && (state_q == ST_IDLE) && !hold;

  tx_arbiter u_arbiter (
    .enable     (arb_enable),
    .pf_valid   (pf_cmd_valid),
    .ex_valid   (ex_cmd_valid),
    .pf_started (pf_started),
    .ex_started (ex_started),
    .accept     (accept),
    .sel        (src_sel)
  );

  assign cmd_sel    = (src_sel == SRC_EX) ? ex_cmd : pf_cmd;
  assign last_beat  = write_q ? LAST_WRITE : LAST_READ;
  assign tx_source  = (src_q == SRC_EX);
  assign tx_counter = cnt_q;

  // NOTE: every signal written here gets a default first, so no branch
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hdr_cnt_d    = '0;
    cnt_d        = '0;
    pin_d        = '0;
    tx_active    = 1'b1;
    tx_data_next = 1'b0;
    tx_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_active = 1'b0;
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        pin_d   = IO_BITS'(1);
        state_d = ST_HEADER;
      end
      ST_HEADER: begin
        pin_d   = shift_q[IO_BITS-1:0];
        shift_d = shift_q >> IO_BITS;
        if (hdr_cnt_q == HDR_LAST) state_d = ST_PAYLOAD;
        else                       hdr_cnt_d = hdr_cnt_q + 1'b1;
      end
      ST_PAYLOAD: begin
        tx_data_next = 1'b1;
        pin_d        = (src_q == SRC_EX) ? ex_data : pf_data;
        if (cnt_q == last_beat) begin
          tx_done = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_PF;
      shift_q   <= '0;
      write_q   <= 1'b0;
      hdr_cnt_q <= '0;
      cnt_q     <= '0;
      tx_pins   <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      cnt_q     <= cnt_d;
      tx_pins   <= pin_d;
      if (accept) begin
        shift_q <= cmd_sel;
        write_q <= cmd_sel[TX_HDR_BIT_WRITE];
        src_q   <= src_sel;
      end else begin
        shift_q <= shift_d;
      end
    end
  end

endmodule

// File: tb/tb_tx_engine.sv
// Self-checking bench for tx_engine: a message-offset model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tx_engine;
  import tx_engine_pkg::*;

  localparam int IO = 2;
  localparam int PC = 8;
  localparam int CB = 4;
  localparam int HB = CB / IO;
  localparam int CW = $clog2(PC) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          pf_cmd_valid = 1'b0;
  logic          ex_cmd_valid = 1'b0;
  logic [CB-1:0] pf_cmd = '0;
  logic [CB-1:0] ex_cmd = '0;
  logic [IO-1:0] pf_data = '0;
  logic [IO-1:0] ex_data = '0;
  logic          pf_started, ex_started, tx_active, tx_source;
  logic          tx_data_next, tx_done;
  logic [CW-1:0] tx_counter;
  logic [IO-1:0] tx_pins;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tx_engine #(.IO_BITS(IO), .PAYLOAD_CYCLES(PC), .TX_CMD_BITS(CB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .pf_cmd_valid (pf_cmd_valid),
    .pf_cmd       (pf_cmd),
    .pf_started   (pf_started),
    .pf_data      (pf_data),
    .ex_cmd_valid (ex_cmd_valid),
    .ex_cmd       (ex_cmd),
    .ex_started   (ex_started),
    .ex_data      (ex_data),
    .tx_active    (tx_active),
    .tx_source    (tx_source),
    .tx_data_next (tx_data_next),
    .tx_counter   (tx_counter),
    .tx_done      (tx_done),
    .tx_pins      (tx_pins)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a message is a span of offsets 1..len after acceptance
  // (1 = start, then header chunks, payload beats, gap); wire = pin one cycle late.
  initial begin : model
    bit            busy = 0;
    int            off = 0;
    int            beats = 0;
    bit            msrc = 0;
    logic [CB-1:0] mcmd = '0;
    logic [IO-1:0] mpins = '0;
    bit            acc, asrc, e_ps, e_es, e_act, e_next, e_done;
    int            e_cnt, p;
    logic [IO-1:0] pin;
    forever begin
      @(negedge clk);
      acc = 0; asrc = 0; pin = '0; e_cnt = 0;
      e_ps = 0; e_es = 0; e_act = 0; e_next = 0; e_done = 0;
      if (!rst_n) begin
        busy = 0;
        mpins = '0;
      end else if (!busy) begin
        if (!hold && (ex_cmd_valid || pf_cmd_valid)) begin
          acc  = 1;
          asrc = ex_cmd_valid;
          e_es = ex_cmd_valid;
          e_ps = !ex_cmd_valid;
        end
      end else begin
        e_act = 1;
        if (off == 1) pin = IO'(1);
        else if (off <= 1 + HB) pin = IO'(mcmd >> (IO * (off - 2)));
        else if (off <= 1 + HB + beats) begin
          p      = off - 2 - HB;
          e_next = 1;
          e_cnt  = p;
          e_done = (p == beats - 1);
          pin    = msrc ? ex_data : pf_data;
        end
      end
      check("m_pf_started", pf_started, e_ps);
      check("m_ex_started", ex_started, e_es);
      check("m_tx_active", tx_active, e_act);
      check("m_tx_data_next", tx_data_next, e_next);
      check("m_tx_counter", tx_counter, e_cnt);
      check("m_tx_done", tx_done, e_done);
      check("m_tx_pins", tx_pins, mpins);
      if (e_act) check("m_tx_source", tx_source, msrc);
      @(posedge clk);
      if (!rst_n) begin
        busy = 0;
        mpins = '0;
      end else begin
        mpins = pin;
        if (acc) begin
          busy  = 1;
          off   = 1;
          msrc  = asrc;
          mcmd  = asrc ? ex_cmd : pf_cmd;
          beats = mcmd[TX_HDR_BIT_WRITE] ? 2 * PC : PC;
        end else if (busy) begin
          off++;
          if (off > 2 + HB + beats) busy = 0;
        end
      end
    end
  end

  task automatic t_pf_read();
    int exp_pins[14] = '{0, 1, 1, 0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    int act_n = 0, done_n = 0, done_cnt = -1;
    pf_cmd = TX_HEADER_READ_16; pf_cmd_valid = 1; pf_data = 3;
    @(negedge clk);
    check("t1_pf_started", pf_started, 1);
    check("t1_ex_started", ex_started, 0);
    step();
    pf_cmd_valid = 0; pf_cmd = 4'hE;
    for (int k = 1; k <= 14; k++) begin
      pf_data = (k >= 4) ? IO'(k - 4) : IO'(3);
      @(negedge clk);
      check($sformatf("t1_pins_%0d", k), tx_pins, exp_pins[k-1]);
      if (tx_active) act_n++;
      if (tx_done) begin done_n++; done_cnt = tx_counter; end
      step();
    end
    check("t1_active_cycles", act_n, 12);
    check("t1_done_count", done_n, 1);
    check("t1_done_counter", done_cnt, 7);
  endtask

  task automatic t_ex_write();
    int act_n = 0, done_n = 0, done_cnt = -1, src_bad = 0, max_cnt = 0;
    ex_cmd = TX_HEADER_WRITE_16; ex_cmd_valid = 1; ex_data = 1;
    @(negedge clk);
    check("t2_ex_started", ex_started, 1);
    step();
    ex_cmd_valid = 0;
    for (int k = 1; k <= 22; k++) begin
      ex_data = IO'(k * 3);
      @(negedge clk);
      if (tx_active) act_n++;
      if (tx_active && tx_source !== 1'b1) src_bad++;
      if (tx_data_next && int'(tx_counter) > max_cnt) max_cnt = int'(tx_counter);
      if (tx_done) begin done_n++; done_cnt = tx_counter; end
      step();
    end
    check("t2_active_cycles", act_n, 20);
    check("t2_done_count", done_n, 1);
    check("t2_done_counter", done_cnt, 15);
    check("t2_max_counter", max_cnt, 15);
    check("t2_source_bad", src_bad, 0);
  endtask

  task automatic t_both_valid();
    int first = -1, done_k = -1;
    pf_cmd = TX_HEADER_READ_16; ex_cmd = TX_HEADER_READ_8;
    pf_cmd_valid = 1; ex_cmd_valid = 1;
    @(negedge clk);
    check("t3_ex_started", ex_started, 1);
    check("t3_pf_started", pf_started, 0);
    step();
    ex_cmd_valid = 0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (pf_started && first < 0) first = k;
      if (tx_done && done_k < 0) done_k = k;
      step();
      if (first >= 0) pf_cmd_valid = 0;
    end
    check("t3_pf_start_cycle", first, 13);
    check("t3_done_to_start", first - done_k, 2);
  endtask

  task automatic t_hold();
    int done_n = 0;
    hold = 1; pf_cmd_valid = 1; pf_cmd = TX_HEADER_WRITE_8;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_held_started", pf_started, 0);
      check("t4_held_pins", tx_pins, 0);
      step();
    end
    hold = 0;
    @(negedge clk);
    check("t4_release_started", pf_started, 1);
    step();
    pf_cmd_valid = 0;
    for (int k = 1; k <= 22; k++) begin
      if (k == 5) hold = 1;
      @(negedge clk);
      if (tx_done) done_n++;
      step();
    end
    hold = 0;
    check("t4_done_count", done_n, 1);
  endtask

  task automatic t_reset_mid();
    int first_cnt = -1, done_n = 0;
    pf_cmd = TX_HEADER_READ_16; pf_cmd_valid = 1; pf_data = 2;
    @(negedge clk);
    check("t5_pf_started", pf_started, 1);
    step();
    pf_cmd_valid = 0;
    repeat (6) step();
    check("t5_beat3_counter", tx_counter, 3);
    check("t5_beat3_next", tx_data_next, 1);
    rst_n = 0;
    #1;
    check("t5_rst_counter", tx_counter, 0);
    check("t5_rst_active", tx_active, 0);
    check("t5_rst_done", tx_done, 0);
    check("t5_rst_next", tx_data_next, 0);
    check("t5_rst_pins", tx_pins, 0);
    repeat (2) step();
    rst_n = 1;
    step();
    pf_cmd = TX_HEADER_READ_8; pf_cmd_valid = 1;
    @(negedge clk);
    check("t5_fresh_started", pf_started, 1);
    step();
    pf_cmd_valid = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (tx_data_next && first_cnt < 0) first_cnt = tx_counter;
      if (tx_done) done_n++;
      step();
    end
    check("t5_first_counter", first_cnt, 0);
    check("t5_done_count", done_n, 1);
  endtask

  task automatic t_back_to_back();
    int s_k[2] = '{-1, -1};
    int n_s = 0, done_k = -1, gap_act = 0;
    logic [IO-1:0] wire_q[29];
    pf_cmd = TX_HEADER_READ_8; pf_data = 3; pf_cmd_valid = 1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      wire_q[k] = tx_pins;
      if (pf_started && n_s < 2) begin s_k[n_s] = k; n_s++; end
      if (tx_done && done_k < 0) done_k = k;
      if (done_k >= 0 && k > done_k && n_s < 2 && tx_active) gap_act++;
      step();
      if (n_s == 2) pf_cmd_valid = 0;
    end
    check("t6_first_start", s_k[0], 0);
    check("t6_second_start", s_k[1], 13);
    check("t6_gap_cycles", gap_act, 1);
    check("t6_last_payload_wire", wire_q[12], 3);
    check("t6_gap_wire", wire_q[13], 0);
    check("t6_second_start_wire", wire_q[15], 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_pins", tx_pins, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_tx_counter", tx_counter, 0);
    check("rst_tx_source", tx_source, 0);
    rst_n = 1;
    step();
    t_pf_read();
    t_ex_write();
    t_both_valid();
    t_hold();
    t_reset_mid();
    t_back_to_back();
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
